// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared states, line levels and default sizing for the UART transmit framing engine
package uart_tx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
   localparam logic TX_IDLE_LEVEL  = 1'b1;
   localparam logic TX_START_LEVEL = 1'b0;
   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;
endpackage

// File: rtl/uart_tx_tick_cnt.sv
// uart_tx_tick_cnt: counts oversampling ticks within one bit and flags the bit's terminal tick
module uart_tx_tick_cnt
   import uart_tx_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_bit_done
);
   localparam int W = $clog2(OVERSAMPLE);
   localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);
   logic [W-1:0] r_cnt;
   // OVERSAMPLE is a power of two, so the natural wrap returns the count to 0 after the terminal tick
   always_ff @(posedge clk) begin
      r_cnt <= (reset || i_clr) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
   end
   assign o_bit_done = i_en && (r_cnt == LAST);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framing (start, LSB-first data, optional parity, stop).
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx_frame
   import uart_tx_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Tx_EN,
   input  logic                 Tx_WR,
   input  logic [DATA_BITS-1:0] Tx_DATA,
   input  logic                 Tx_sample_ENABLE,
   output logic                 TxD,
   output logic                 Tx_BUSY
);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
   tx_state_t r_state, w_state;
   logic r_txd, w_txd, r_busy, w_busy;
   logic [DATA_BITS-1:0] r_shift, w_shift;
   logic [IW-1:0] r_idx, w_idx;
   logic w_accept, w_bit_done;
`ifdef UART_TX_PARITY_EN
   logic r_par, w_par;
`endif
   if (OVERSAMPLE < 2 || OVERSAMPLE > 16 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
       DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_frame: unsupported parameter set");
   end
   uart_tx_tick_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_tick (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (r_state == IDLE),
      .i_en      (Tx_sample_ENABLE),
      .o_bit_done(w_bit_done)
   );
   assign w_accept = Tx_WR && Tx_EN && !r_busy;
   always_comb begin
      w_state = r_state;
      w_txd   = r_txd;
      w_busy  = r_busy;
      w_shift = r_shift;
      w_idx   = r_idx;
`ifdef UART_TX_PARITY_EN
      w_par   = r_par;
`endif
      case (r_state)
         IDLE: if (w_accept) begin
            w_state = START;
            w_busy  = 1'b1;
            w_txd   = TX_START_LEVEL;
            w_shift = Tx_DATA;
            w_idx   = '0;
`ifdef UART_TX_PARITY_EN
            w_par   = ^Tx_DATA ^ (PARITY_ODD != 0);
`endif
         end
         START: if (w_bit_done) begin
            w_state = DATA;
            w_txd   = r_shift[0];
            w_shift = r_shift >> 1;
         end
         DATA: if (w_bit_done) begin
            if (r_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               w_state = PARITY;
               w_txd   = r_par;
`else
               w_state = STOP;
               w_txd   = TX_IDLE_LEVEL;
`endif
            end else begin
               w_txd   = r_shift[0];
               w_shift = r_shift >> 1;
               w_idx   = r_idx + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (w_bit_done) begin
            w_state = STOP;
            w_txd   = TX_IDLE_LEVEL;
         end
`endif
         STOP: if (w_bit_done) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_txd   = TX_IDLE_LEVEL;
         end
         default: w_state = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_txd   <= TX_IDLE_LEVEL;
         r_busy  <= 1'b0;
         r_shift <= '0;
         r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_txd   <= w_txd;
         r_busy  <= w_busy;
         r_shift <= w_shift;
         r_idx   <= w_idx;
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par;
`endif
      end
   end
   assign TxD     = r_txd;
   assign Tx_BUSY = r_busy;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven and randomized frame checks against a tick-count line model
module tb_uart_tx_frame;
   localparam int OS   = 16;
   localparam int DB   = 8;
   localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DB + 3;
`else
   localparam int NB = DB + 2;
`endif
   localparam int TOTAL = NB * OS;

   logic clk = 1'b0, reset = 1'b1, Tx_EN = 1'b1, Tx_WR = 1'b0, Tx_sample_ENABLE = 1'b0;
   logic [DB-1:0] Tx_DATA = '0;
   logic TxD, Tx_BUSY;
   int checks = 0, failures = 0, tick_period = 1, ph = 0, cyc_g = 0;

   typedef struct {
      logic [7:0] data;
      int         period;
      logic [9:0] pat;
      string      name;
   } vec_t;
   vec_t vecs[6];

   uart_tx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
      .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
      .Tx_sample_ENABLE(Tx_sample_ENABLE), .TxD(TxD), .Tx_BUSY(Tx_BUSY)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_g <= cyc_g + 1;
   initial forever begin
      @(negedge clk);
      Tx_sample_ENABLE = (tick_period > 0) && ((ph % tick_period) == 0);
      ph = ph + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // line sequence in send order: pat[9] is the start bit, pat[0] the stop bit
   function automatic logic [9:0] pat_of(input logic [7:0] d);
      logic [9:0] p;
      p[9] = 1'b0;
      for (int i = 0; i < 8; i++) p[8-i] = d[i];
      p[0] = 1'b1;
      return p;
   endfunction

   function automatic logic [NB-1:0] mkpat(input logic [9:0] p10, input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      logic par;
      par = (^d) ^ (PODD != 0);
      return {p10[9:1], par, 1'b1};
`else
      if (d == 8'h00 && p10 == 10'h3FF) return '1;
      return p10;
`endif
   endfunction

   // model: after the accepting edge, the line shows bit floor(ticks/OS) of the frame until all ticks are consumed
   task automatic run_frame(input logic [7:0] data, input int period, input logic [NB-1:0] pat,
                            input int inj_at, input bit rand_en, input string name,
                            output int t_start, output int t_end);
      int ticks, cyc, mism, busy_cyc, budget, exp_txd, exp_busy, first_bad;
      ticks = 0; cyc = 0; mism = 0; busy_cyc = 0; first_bad = -1;
      budget = TOTAL * period + 40;
      tick_period = period;
      @(negedge clk);
      Tx_DATA = data;
      Tx_WR = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
      t_start = cyc_g;
      forever begin
         exp_txd  = (ticks >= TOTAL) ? 1 : int'(pat[NB-1-ticks/OS]);
         exp_busy = (ticks < TOTAL) ? 1 : 0;
         if (int'(TxD) != exp_txd || int'(Tx_BUSY) != exp_busy) begin
            mism++;
            if (first_bad < 0) first_bad = cyc;
         end
         if (Tx_BUSY) busy_cyc++;
         if (ticks >= TOTAL || cyc >= budget) break;
         Tx_WR = (cyc == inj_at);
         Tx_DATA = (cyc == inj_at) ? ~data : 8'($urandom);
         if (rand_en) Tx_EN = 1'($urandom);
         @(posedge clk);
         if (Tx_sample_ENABLE) ticks++;
         #1;
         cyc++;
      end
      t_end = cyc_g;
      Tx_WR = 1'b0;
      Tx_EN = 1'b1;
      if (ticks < TOTAL) mism++;
      if (mism != 0) $display("  %s first bad cycle %0d", name, first_bad);
      chk({name, "_wave_mismatches"}, mism, 0);
      if (period == 1) chk({name, "_busy_cycles"}, busy_cyc, TOTAL);
   endtask

   task automatic idle_busy_count(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (Tx_BUSY) cnt++;
      end
   endtask

   initial begin
      int ts, te, ts2, te2, cnt;
      logic [7:0] d;
      vecs[0] = '{8'h55, 1, 10'b0101010101, "basic_55"};
      vecs[1] = '{8'hA3, 10, 10'b0110001011, "sparse_A3"};
      vecs[2] = '{8'h07, 1, 10'b0111000001, "par_07"};
      vecs[3] = '{8'h00, 1, 10'b0000000001, "zero"};
      vecs[4] = '{8'hFF, 2, 10'b0111111111, "ones"};
      vecs[5] = '{8'h80, 3, 10'b0000000011, "msb_80"};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_txd", int'(TxD), 1);
      chk("reset_busy", int'(Tx_BUSY), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i])
         run_frame(vecs[i].data, vecs[i].period, mkpat(vecs[i].pat, vecs[i].data), -1, 1'b0, vecs[i].name, ts, te);

      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         run_frame(d, $urandom_range(1, 4), mkpat(pat_of(d), d), -1, 1'b1, "rand", ts, te);
      end

      // write during the data bits of an all-zero frame must be ignored
      run_frame(8'h00, 1, mkpat(pat_of(8'h00), 8'h00), 40, 1'b0, "rej_mid", ts, te);
      idle_busy_count(20, cnt);
      chk("rej_mid_no_second_frame", cnt, 0);

      // write with the transmitter disabled
      Tx_EN = 1'b0;
      @(negedge clk);
      Tx_DATA = 8'h5A;
      Tx_WR = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
      Tx_EN = 1'b1;
      chk("en0_busy", int'(Tx_BUSY), 0);
      chk("en0_txd", int'(TxD), 1);

      // write coinciding with the final stop tick
      run_frame(8'h5A, 1, mkpat(pat_of(8'h5A), 8'h5A), TOTAL - 1, 1'b0, "rej_last", ts, te);
      idle_busy_count(5, cnt);
      chk("rej_last_no_second_frame", cnt, 0);

      // reset during data bit 4 of an all-zero frame
      tick_period = 1;
      @(negedge clk);
      Tx_DATA = 8'h00;
      Tx_WR = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
      repeat (OS + 4 * OS + 5) @(posedge clk);
      #1;
      chk("pre_reset_txd", int'(TxD), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset_txd", int'(TxD), 1);
      chk("mid_reset_busy", int'(Tx_BUSY), 0);
      reset = 1'b0;
      run_frame(8'h3C, 1, mkpat(10'b0001111001, 8'h3C), -1, 1'b0, "post_reset_3C", ts, te);

      // back-to-back frames: second write lands in the first idle cycle
      run_frame(8'h12, 1, mkpat(pat_of(8'h12), 8'h12), -1, 1'b0, "b2b_12", ts, te);
      run_frame(8'h34, 1, mkpat(pat_of(8'h34), 8'h34), -1, 1'b0, "b2b_34", ts2, te2);
      chk("b2b_gap_cycles", ts2 - te, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framing engine for the Part B transmitter. Sits directly downstream of the baud-rate sample-enable generator and the oversampling tick counting, and drives the serial line. Accepts one parallel byte per `Tx_WR` and shifts out start bit, data LSB-first, optional parity, and stop bit, holding each bit for a fixed number of `Tx_sample_ENABLE` pulses.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–8).
- `OVERSAMPLE`, 16: `Tx_sample_ENABLE` pulses per bit (power of two, 2–16).
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Used only when parity is compiled in.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `Tx_EN`  in  1  transmitter enable; gates acceptance of new writes only.
- `Tx_WR`  in  1  single-cycle write strobe.
- `Tx_DATA`  in  `DATA_BITS`  byte to send; sampled on the accepting edge.
- `Tx_sample_ENABLE`  in  1  one-cycle oversampling tick from the baud controller.
- `TxD`  out  1  serial line; registered; idles high.
- `Tx_BUSY`  out  1  high while a frame is in progress; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset forces state = IDLE, `TxD` = 1, `Tx_BUSY` = 0, the tick count to 0, the bit index to 0, and the shift register to 0.
- **Accept:** the block accepts a write on the edge where `Tx_WR`=1, `Tx_EN`=1 and `Tx_BUSY`=0.
  - On that edge, `Tx_DATA` is latched into the shift register.
  - Parity is computed and latched: XOR of the data bits, inverted if `PARITY_ODD`.
  - The tick count clears to 0.
  - State moves to START, `Tx_BUSY` goes to 1, and `TxD` goes to 0.
- **Write rejected:** `Tx_WR` is ignored when `Tx_BUSY`=1 or `Tx_EN`=0. There is no queueing and no error flag.
- **Tick counting:** the tick count increments on each `Tx_sample_ENABLE`. On the edge consuming the `OVERSAMPLE`-th tick of a bit:
  - the count wraps to 0;
  - the next bit value is driven onto `TxD` on that same edge.
- **Bit sequence:**
  - START (`TxD`=0) → DATA.
  - DATA drives bit[0] first, shifting right. After `DATA_BITS` bits it goes to PARITY if parity is compiled in, else to STOP.
  - PARITY (`TxD` = parity bit) → STOP.
  - STOP (`TxD`=1) → IDLE. `Tx_BUSY` clears on the edge consuming the stop bit's final tick.
- Deasserting `Tx_EN` mid-frame does not abort the frame.
- `Tx_DATA` changes after acceptance have no effect on the frame in progress.
- Reset mid-frame returns to IDLE on the next edge. No partial stop bit is emitted; `TxD` goes high immediately.

## Timing
- Latency from the accepting edge to the start bit on `TxD`: 0 cycles. The start bit is registered on the accepting edge.
- Each bit lasts exactly `OVERSAMPLE` `Tx_sample_ENABLE` pulses. Cycle length depends on the tick period.
- Frame length:
  - `(DATA_BITS+2)·OVERSAMPLE` ticks without parity;
  - `(DATA_BITS+3)·OVERSAMPLE` ticks with parity.
- Back-to-back frames: `Tx_WR` is accepted in the first cycle after `Tx_BUSY` falls, so frames can be separated by the stop bit only.
- `Tx_WR` in the same cycle as the final stop tick is rejected, because `Tx_BUSY` is still 1 in that cycle.
- `Tx_WR` and `Tx_sample_ENABLE` in the same cycle in IDLE: the write is accepted and the tick is discarded, because the tick count clears.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state and the parity register exist;
  - the frame is start + data + parity + stop;
  - `PARITY_ODD` is honoured.
- Not defined:
  - PARITY is removed and DATA goes directly to STOP;
  - the frame is start + data + stop;
  - `PARITY_ODD` is ignored.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the `TX_IDLE_LEVEL` and `TX_START_LEVEL` constants;
  - the default `OVERSAMPLE` and `DATA_BITS` constants.
- One sub-module: `uart_tx_tick_cnt`.
  - Behaviour: a `$clog2(OVERSAMPLE)`-bit tick counter with synchronous clear and enable, and a `bit_done` output asserted on the terminal tick.
  - The FSM, shift register, bit index and parity live in the top module.

## Test plan
- **Basic frame:** `Tx_sample_ENABLE` tied high, no parity, write 0x55 → `TxD` holds each of 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop) for 16 cycles. `Tx_BUSY` is high for exactly 160 cycles.
- **Parity:** with `UART_TX_PARITY_EN`, write 0x07 → parity bit = 1 (even). With `PARITY_ODD`=1 the parity bit = 0. Frame length is 176 ticks.
- **Sparse ticks:** `Tx_sample_ENABLE` pulses every 10 cycles, write 0xA3 → each bit lasts 160 cycles. The bit pattern is 0,1,1,0,0,0,1,0,1,1.
- **Rejected writes:**
  - `Tx_WR` with 0xFF during the DATA state of a 0x00 frame → the frame stays all-zero data and no second frame follows.
  - `Tx_WR` with `Tx_EN`=0 → `Tx_BUSY` stays 0.
- **Reset mid-frame:** assert `reset` during bit 4 of the data → the next cycle shows `TxD`=1 and `Tx_BUSY`=0. A following write of 0x3C transmits a complete, correct frame.
- **Back-to-back:** write 0x12, then 0x34 in the first cycle `Tx_BUSY`=0 → the two frames are contiguous with no idle gap beyond the stop bit.
